// File: rtl/exmem_skid_pkg.sv
// Shared MIPS EX/MEM definitions: datapath widths, skid FIFO depth and ctrl bit map.
package exmem_skid_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_REG_W  = 5;
    localparam int FIFO_DEPTH  = 2;

    localparam int CTRL_W        = 3;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_BRANCH   = 0;

endpackage

// File: rtl/exmem_entry.sv
// One EX/MEM FIFO slot: load-enabled register cleared by the asynchronous reset.
module exmem_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/exmem_skid.sv
// EX/MEM boundary as a 2-entry in-order skid FIFO; ready/valid derived from registered occupancy only.
module exmem_skid
    import exmem_skid_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int REG_W  = MIPS_REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] aluresult,
    input  logic              zero,
    input  logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] pcbranch,
    input  logic [REG_W-1:0]  writereg,
    input  logic [CTRL_W-1:0] ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_aluresult,
    output logic [DATA_W-1:0] out_writedata,
    output logic [DATA_W-1:0] out_pcbranch,
    output logic [REG_W-1:0]  out_writereg,
    output logic [1:0]        out_ctrl,
    output logic              pcsrc,
    output logic [7:0]        taken_count
);

    localparam int ENTRY_W = 3*DATA_W + REG_W + 3;

    logic [1:0] count;
    logic       head;
    logic       tail;
    logic       push;
    logic       pop;

    logic [ENTRY_W-1:0] entry_d;
    logic [ENTRY_W-1:0] slot_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head_q;

    logic [DATA_W-1:0] h_alu;
    logic [DATA_W-1:0] h_wd;
    logic [DATA_W-1:0] h_pcb;
    logic [REG_W-1:0]  h_wr;
    logic              h_rw;
    logic              h_mw;
    logic              h_pcsrc;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // pcsrc is resolved at push so the head carries a ready-made taken flag.
    assign entry_d = {aluresult, writedata, pcbranch, writereg,
                      ctrl[CTRL_REGWRITE], ctrl[CTRL_MEMWRITE],
                      ctrl[CTRL_BRANCH] & zero};

    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_slot
        exmem_entry #(.W(ENTRY_W)) u_entry (
            .clk   (clk),
            .reset (reset),
            .en    (push & ~flush & (tail == 1'(i))),
            .d     (entry_d),
            .q     (slot_q[i])
        );
    end

    assign head_q = slot_q[head];
    assign {h_alu, h_wd, h_pcb, h_wr, h_rw, h_mw, h_pcsrc} = head_q;

    assign out_aluresult = out_valid ? h_alu : '0;
    assign out_writedata = out_valid ? h_wd  : '0;
    assign out_pcbranch  = out_valid ? h_pcb : '0;
    assign out_writereg  = out_valid ? h_wr  : '0;
    assign out_ctrl      = out_valid ? {h_rw, h_mw} : 2'b00;
    assign pcsrc         = out_valid & h_pcsrc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push)
                tail <= ~tail;
            if (pop)
                head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // A pop in a flush cycle still reaches the memory stage, so it is counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            taken_count <= 8'd0;
        else if (pop && h_pcsrc && (taken_count != 8'hFF))
            taken_count <= taken_count + 8'd1;
    end

endmodule

// File: tb/tb_exmem_skid.sv
// Scoreboard bench for exmem_skid: a queue model of the FIFO checks every delivered entry.
module tb_exmem_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] aluresult;
    logic        zero;
    logic [31:0] writedata;
    logic [31:0] pcbranch;
    logic [4:0]  writereg;
    logic [2:0]  ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_aluresult;
    logic [31:0] out_writedata;
    logic [31:0] out_pcbranch;
    logic [4:0]  out_writereg;
    logic [1:0]  out_ctrl;
    logic        pcsrc;
    logic [7:0]  taken_count;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pcb;
        logic [4:0]  wr;
        logic [1:0]  ctl;
        logic        pc;
    } exp_t;

    exp_t q[$];
    int   tc_model = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exmem_skid dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .aluresult     (aluresult),
        .zero          (zero),
        .writedata     (writedata),
        .pcbranch      (pcbranch),
        .writereg      (writereg),
        .ctrl          (ctrl),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_aluresult (out_aluresult),
        .out_writedata (out_writedata),
        .out_pcbranch  (out_pcbranch),
        .out_writereg  (out_writereg),
        .out_ctrl      (out_ctrl),
        .pcsrc         (pcsrc),
        .taken_count   (taken_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Model: inputs change only #1 after posedge, so at negedge they show what the next edge does.
    always @(negedge clk) begin
        if (reset) begin
            exp_t e;
            exp_t n;
            logic do_push;
            check_eq("occ_valid", out_valid, q.size() != 0);
            check_eq("occ_ready", in_ready, q.size() < 2);
            check_eq("taken", taken_count, tc_model);
            if (q.size() == 0) begin
                check_eq("idle_alu", out_aluresult, 0);
                check_eq("idle_pcb", out_pcbranch, 0);
                check_eq("idle_misc", {out_writedata, out_writereg, out_ctrl, pcsrc}, 0);
            end
            do_push = in_valid && (q.size() < 2);
            if (out_ready && q.size() != 0) begin
                e = q.pop_front();
                check_eq("alu", out_aluresult, e.alu);
                check_eq("wd", out_writedata, e.wd);
                check_eq("pcb", out_pcbranch, e.pcb);
                check_eq("wr", out_writereg, e.wr);
                check_eq("ctrl", out_ctrl, e.ctl);
                check_eq("pcsrc", pcsrc, e.pc);
                if (e.pc && tc_model != 255)
                    tc_model++;
            end
            if (flush) begin
                q.delete();
            end else if (do_push) begin
                n.alu = aluresult;
                n.wd  = writedata;
                n.pcb = pcbranch;
                n.wr  = writereg;
                n.ctl = ctrl[2:1];
                n.pc  = ctrl[0] & zero;
                q.push_back(n);
            end
        end
    end

    task automatic offer(input logic [31:0] a, input logic [31:0] w, input logic [31:0] p,
                         input logic [4:0] r, input logic [2:0] c, input logic z);
        aluresult = a;
        writedata = w;
        pcbranch  = p;
        writereg  = r;
        ctrl      = c;
        zero      = z;
        in_valid  = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] w, input logic [31:0] p,
                            input logic [4:0] r, input logic [2:0] c, input logic z);
        offer(a, w, p, r, c, z);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++)
            step();
        check_eq(tag, q.size(), 0);
    endtask

    initial begin
        int tc0;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        aluresult = '0; writedata = '0; pcbranch = '0; writereg = '0; ctrl = '0; zero = 1'b0;

        // Reset state, checked while reset is still held
        #12;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_pcsrc", pcsrc, 0);
        check_eq("rst_fields", {out_aluresult, out_writedata, out_pcbranch, out_writereg, out_ctrl}, 0);
        check_eq("rst_taken", taken_count, 0);
        step();
        reset = 1'b1;
        step();

        // Single regwrite entry, one cycle latency, empty afterwards
        out_ready = 1'b1;
        push_one(32'h10, 32'h0, 32'h0, 5'd3, 3'b100, 1'b0);
        check_eq("single_valid", out_valid, 1);
        check_eq("single_alu", out_aluresult, 32'h10);
        check_eq("single_ctrl", out_ctrl, 2'b10);
        check_eq("single_pcsrc", pcsrc, 0);
        step();
        check_eq("single_empty", out_valid, 0);

        // Backpressure: A and B held, C refused, then A then B delivered
        out_ready = 1'b0;
        push_one(32'h1, 32'hA1, 32'h100, 5'd1, 3'b110, 1'b0);
        push_one(32'h2, 32'hB2, 32'h200, 5'd2, 3'b010, 1'b1);
        check_eq("full_in_ready", in_ready, 0);
        offer(32'h3, 32'hC3, 32'h300, 5'd4, 3'b100, 1'b0);
        step();
        step();
        in_valid = 1'b0;
        check_eq("full_hold_alu", out_aluresult, 32'h1);
        drain("bp_drain");

        // Flush at occupancy 2 beats a simultaneous push
        out_ready = 1'b0;
        push_one(32'h11, 32'h0, 32'h0, 5'd5, 3'b100, 1'b0);
        push_one(32'h22, 32'h0, 32'h0, 5'd6, 3'b100, 1'b0);
        offer(32'h33, 32'h0, 32'h0, 5'd7, 3'b100, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_ready", in_ready, 1);
        step();
        check_eq("flush_discard", out_valid, 0);

        // Taken branch popped in a flush cycle still counts
        tc0 = taken_count;
        push_one(32'h44, 32'h0, 32'h0040_0040, 5'd0, 3'b001, 1'b1);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_pop_count", taken_count, tc0 + 1);
        check_eq("flush_pop_empty", out_valid, 0);

        // Asynchronous reset mid-cycle with one entry held
        out_ready = 1'b0;
        push_one(32'h55, 32'h0, 32'h0, 5'd8, 3'b100, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_valid", out_valid, 0);
        check_eq("arst_ready", in_ready, 1);
        check_eq("arst_alu", out_aluresult, 0);
        check_eq("arst_taken", taken_count, 0);
        q.delete();
        tc_model = 0;
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        check_eq("arst_no_output", out_valid, 0);

        // One taken branch
        push_one(32'h0, 32'h0, 32'h0040_0020, 5'd0, 3'b001, 1'b1);
        check_eq("br_pcsrc", pcsrc, 1);
        check_eq("br_pcb", out_pcbranch, 32'h0040_0020);
        step();
        check_eq("br_count", taken_count, 1);

        // Streaming 300 taken branches: push and pop each cycle at occupancy 1, count saturates
        offer(32'h0, 32'h0, 32'h0040_0020, 5'd0, 3'b001, 1'b1);
        for (int i = 0; i < 300; i++) begin
            aluresult = i;
            step();
        end
        in_valid = 1'b0;
        drain("sat_drain");
        check_eq("sat_count", taken_count, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exmem_skid.md
EXMEM_SKID -- requirements
Module: exmem_skid

Interface
REQ-001 Parameter: DATA_W, 32, width of result/writedata/pcbranch fields.
REQ-002 Parameter: REG_W, 5, width of destination register index.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: flush  input  1  synchronous discard of all held entries.
REQ-006 Port: in_valid  input  1  upstream (ALU stage) offers an entry.
REQ-007 Port: in_ready  output  1  block can accept an entry this cycle.
REQ-008 Port: aluresult  input  DATA_W  ALU result.
REQ-009 Port: zero  input  1  ALU zero flag.
REQ-010 Port: writedata  input  DATA_W  store data.
REQ-011 Port: pcbranch  input  DATA_W  branch target.
REQ-012 Port: writereg  input  REG_W  destination register.
REQ-013 Port: ctrl  input  3  {regwrite, memwrite, branch}.
REQ-014 Port: out_valid  output  1  head entry presented downstream.
REQ-015 Port: out_ready  input  1  downstream (memory stage) accepts head.
REQ-016 Port: out_aluresult, out_writedata, out_pcbranch  output  DATA_W each  head fields.
REQ-017 Port: out_writereg  output  REG_W; out_ctrl  output  2 {regwrite, memwrite}.
REQ-018 Port: pcsrc  output  1  head entry is a taken branch.
REQ-019 Port: taken_count  output  8  saturating count of taken branches delivered.

Function
REQ-020 Block SHALL be a 2-entry in-order FIFO; push = in_valid & in_ready, pop = out_valid & out_ready.
REQ-021 in_ready SHALL equal (occupancy < 2), derived from registered occupancy only; no combinational path from out_ready.
REQ-022 out_valid SHALL equal (occupancy > 0); latency push-to-out_valid is exactly 1 cycle; no same-cycle bypass.
REQ-023 pcsrc of an entry SHALL be branch & zero, computed and stored at push.
REQ-024 When out_valid=0, all out_* fields and pcsrc SHALL be driven 0.
REQ-025 Push and pop in the same cycle at occupancy 1 SHALL leave occupancy 1 with new entry at head next cycle.
REQ-026 At occupancy 2 push is impossible (in_ready=0); a pop frees one slot, in_ready=1 next cycle.
REQ-027 Head/tail pointers SHALL be 1 bit and wrap 1->0.
REQ-028 flush=1 SHALL set occupancy 0 next cycle, has priority over same-cycle push and pop; a popped entry in that cycle still counts toward taken_count.
REQ-029 taken_count SHALL increment by 1 on each pop with pcsrc=1, saturating at 255; flush does not clear it.
REQ-030 Entry field storage SHALL not be cleared on pop; only pointers/occupancy change.

Reset
REQ-031 reset=0 SHALL immediately clear occupancy, pointers and taken_count, independent of clk.
REQ-032 During and after reset: out_valid=0, in_ready=1, pcsrc=0, all out_* fields 0, taken_count=0.
REQ-033 Reset asserted mid-transfer SHALL discard held entries; no entry delivered after reset release until a new push.

Structure
REQ-034 DATA_W, REG_W, FIFO depth (2) and ctrl bit positions SHALL live in the shared mips definitions package/include.
REQ-035 One sub-module exmem_entry (enabled data register, async active-low reset) SHALL be instantiated per slot.

Verification
REQ-036 Single push aluresult=0x0000_0010, zero=0, ctrl=3'b100, out_ready=1 -> out_valid next cycle, out_aluresult=0x10, out_ctrl=2'b10, pcsrc=0, empty following cycle.
REQ-037 out_ready=0, push A=0x1, B=0x2 -> in_ready=0 after second push; third offer C ignored; release out_ready -> A then B delivered in order.
REQ-038 Push branch with zero=1, pcbranch=0x0040_0020, pop -> pcsrc=1, out_pcbranch=0x0040_0020, taken_count=1; 300 such pops -> taken_count=255.
REQ-039 Occupancy 2 plus flush=1 with simultaneous in_valid=1 -> out_valid=0, in_ready=1 next cycle; pushed entry discarded.
REQ-040 reset=0 asserted between clock edges with occupancy 1 -> out_valid=0 immediately; after release no output until new push.
